uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, the next generation of the fixed-format transmitter. It serialises words onto a single tx line and supports the following at run time:
- 5-9 data bits
- none/even/odd/mark/space parity
- 1 or 2 stop bits
- a programmable baud divisor
A one-entry holding register behind a valid/ready handshake allows back-to-back frames with no idle gap. It sits between the interface-bridge logic and the external pin.

Parameters:
DATA_W, 9, maximum data bits per frame; width of s_data.
DIV_W, 16, width of the baud divisor.
IDLE_LEVEL, 1, line level in idle and stop bits; start bit is its inverse.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_data  in  DATA_W  word to send, LSB first; bits above data_bits ignored
s_valid  in  1  s_data valid
s_ready  out  1  holding register empty; transfer when s_valid && s_ready
cfg_data_bits  in  4  data bits per frame, legal 5..DATA_W; values outside clamp to nearest legal
cfg_parity  in  3  0 none, 1 even, 2 odd, 3 mark(1), 4 space(0), 5-7 treated as none
cfg_stop2  in  1  0: one stop bit, 1: two stop bits
cfg_baud_div  in  DIV_W  clocks per bit; 0 treated as 1
tx  out  1  serial line (registered)
tx_busy  out  1  frame in progress on the line
tx_done  out  1  one-cycle pulse in the last clock of the final stop bit

Behaviour:
Reset (rst_n low, asynchronous):
- tx=IDLE_LEVEL, tx_busy=0, tx_done=0, s_ready=1.
- Holding register empty; FSM in IDLE; counters cleared.
- Asserting rst_n mid-frame aborts the frame immediately; tx returns to IDLE_LEVEL with no glitch to the start level.

Holding register:
- Loads on s_valid && s_ready. s_ready is registered: it drops the cycle after the load and rises the cycle after the shifter takes the word.
- The shifter takes the word when in IDLE, or in the last clock of the last stop bit (back-to-back).
- Config is sampled at the same moment as the data. Config changes mid-frame do not affect the frame in flight.

Baud counter:
- Counts 0..div-1 with div=max(cfg_baud_div,1) as latched.
- Every bit lasts exactly div clocks. A bit ends when count==div-1.

FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE or START.
- IDLE: tx=IDLE_LEVEL. When the holding register is full, go to START next cycle. tx shows the start level 1 cycle after the word is taken; in the empty case that is 2 cycles after the s_valid&&s_ready cycle.
- START: tx=~IDLE_LEVEL for div clocks.
- DATA: bit index 0..data_bits-1, LSB first, div clocks each. After the last bit, go to PARITY if parity!=none, else STOP1.
- PARITY: even = XOR of the data_bits used bits; odd = its inverse; mark=1; space=0.
- STOP1/STOP2: tx=IDLE_LEVEL. STOP2 only when cfg_stop2 is latched as 1.
- Last stop bit end: tx_done pulses. If the holding register is full, go directly to START with no idle clock; else go to IDLE.

Outputs:
- tx_busy=1 in every state except IDLE.
- Frame length in clocks = div*(1+data_bits+(parity?1:0)+(stop2?2:1)).

Simultaneous events:
- A new s_valid in the same cycle the shifter empties the holding register is not accepted that cycle, because s_ready is registered low; it is accepted the next cycle.
- A word arriving in IDLE with s_ready high is accepted and transmitted.

Test Plan:
- Reset: rst_n=0 -> tx=1, tx_busy=0, tx_done=0, s_ready=1; release -> no change until s_valid.
- 8N1, div=4, s_data=0x55:
  - tx sequence per bit (4 clocks each): 0,1,0,1,0,1,0,1,0,1.
  - Frame is 40 clocks; tx_done high exactly 1 cycle at clock 40.
- 7E2, div=3, s_data=0x41 (two ones): data 1,0,0,0,0,0,1, then parity 0, stop 1,1 -> 33 clocks. Repeat 7O2 -> parity 1.
- Back-to-back 9M1, div=2, two words 0x1FF then 0x000, second presented while the first transmits: second start bit begins the clock after the first frame's stop bit ends (zero idle); s_ready low between the accept and the shifter take.
- cfg_baud_div=0, cfg_data_bits=3 (clamped to 5), space parity: each bit 1 clock, 5 data bits, parity 0, 8-clock frame.
- Reset mid-DATA (div=8, bit 3): tx=1 asynchronously, tx_busy=0, holding register emptied; next frame after release is a clean start.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter.
// Run-time selectable frame format: 5..DATA_W data bits (LSB first),
// none/even/odd/mark/space parity, one or two stop bits and a baud
// divisor. A one-entry holding register behind a valid/ready handshake
// lets the next word start on the clock after the previous frame's last
// stop bit, so back-to-back frames have no idle gap.
module uart_tx_param #(
    parameter int   DATA_W     = 9,
    parameter int   DIV_W      = 16,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [3:0]        cfg_data_bits,
    input  logic [2:0]        cfg_parity,
    input  logic              cfg_stop2,
    input  logic [DIV_W-1:0]  cfg_baud_div,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam logic [3:0] MIN_BITS = 4'd5;
    localparam logic [3:0] MAX_BITS = 4'(DATA_W);

    // Normalised configuration, captured together with the data word.
    logic [3:0]       cfg_bits_c;
    logic [2:0]       cfg_par_c;
    logic [DIV_W-1:0] cfg_div_m1_c;

    // Holding register.
    logic              hold_empty;
    logic [DATA_W-1:0] hold_data;
    logic [3:0]        hold_bits;
    logic [2:0]        hold_par;
    logic              hold_stop2;
    logic [DIV_W-1:0]  hold_div_m1;
    logic              load;

    // Shifter state and the format of the frame in flight.
    logic [2:0]        state,      state_n;
    logic [DIV_W-1:0]  cnt,        cnt_n;
    logic [3:0]        bit_idx,    bit_idx_n;
    logic [DATA_W-1:0] shreg,      shreg_n;
    logic              par_acc,    par_acc_n;
    logic [3:0]        cur_bits,   cur_bits_n;
    logic [2:0]        cur_par,    cur_par_n;
    logic              cur_stop2,  cur_stop2_n;
    logic [DIV_W-1:0]  cur_div_m1, cur_div_m1_n;
    logic              tx_n;
    logic              bit_end;
    logic              last_end;
    logic              take;

    // Clamp the live configuration into its legal range.
    always_comb begin
        if (cfg_data_bits < MIN_BITS)
            cfg_bits_c = MIN_BITS;
        else if (cfg_data_bits > MAX_BITS)
            cfg_bits_c = MAX_BITS;
        else
            cfg_bits_c = cfg_data_bits;
        cfg_par_c    = (cfg_parity > PAR_SPACE) ? PAR_NONE : cfg_parity;
        cfg_div_m1_c = (cfg_baud_div == '0) ? '0 : cfg_baud_div - DIV_W'(1);
    end

    // s_ready comes straight from a flop, so a word offered in the cycle the
    // shifter empties the holding register is only accepted a cycle later.
    assign s_ready = hold_empty;
    assign load    = s_valid && hold_empty;
    assign tx_busy = (state != ST_IDLE);
    assign tx_done = last_end;

    // Next-state logic for the frame sequencer, baud counter and line level.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n      = state;
        cnt_n        = cnt;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        par_acc_n    = par_acc;
        cur_bits_n   = cur_bits;
        cur_par_n    = cur_par;
        cur_stop2_n  = cur_stop2;
        cur_div_m1_n = cur_div_m1;
        last_end     = 1'b0;
        take         = 1'b0;
        bit_end      = (cnt == cur_div_m1);

        case (state)
            ST_IDLE: begin
                take = !hold_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_n   = ST_DATA;
                    bit_idx_n = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    par_acc_n = par_acc ^ shreg[0];
                    shreg_n   = shreg >> 1;
                    if (bit_idx == cur_bits - 4'd1)
                        state_n = (cur_par == PAR_NONE) ? ST_STOP1 : ST_PARITY;
                    else
                        bit_idx_n = bit_idx + 4'd1;
                end
            end
            ST_PARITY: begin
                if (bit_end)
                    state_n = ST_STOP1;
            end
            ST_STOP1: begin
                if (bit_end) begin
                    if (cur_stop2)
                        state_n = ST_STOP2;
                    else
                        last_end = 1'b1;
                end
            end
            ST_STOP2: begin
                last_end = bit_end;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Every non-idle state runs the baud counter the same way.
        if (state != ST_IDLE)
            cnt_n = bit_end ? '0 : cnt + DIV_W'(1);

        // End of the last stop bit: chain straight into the held word if any.
        if (last_end) begin
            state_n = ST_IDLE;
            take    = !hold_empty;
        end

        if (take) begin
            state_n      = ST_START;
            cnt_n        = '0;
            bit_idx_n    = '0;
            shreg_n      = hold_data;
            par_acc_n    = 1'b0;
            cur_bits_n   = hold_bits;
            cur_par_n    = hold_par;
            cur_stop2_n  = hold_stop2;
            cur_div_m1_n = hold_div_m1;
        end

        // The line is registered from the next state so the start level
        // appears on the same clock the sequencer enters START.
        case (state_n)
            ST_START: tx_n = ~IDLE_LEVEL;
            ST_DATA:  tx_n = shreg_n[0];
            ST_PARITY: begin
                case (cur_par_n)
                    PAR_EVEN: tx_n = par_acc_n;
                    PAR_ODD:  tx_n = ~par_acc_n;
                    PAR_MARK: tx_n = 1'b1;
                    default:  tx_n = 1'b0;
                endcase
            end
            default:  tx_n = IDLE_LEVEL;
        endcase
    end

    // Control state: sequencer, counters, frame format, line and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge, independent of order.
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            par_acc    <= 1'b0;
            cur_bits   <= MIN_BITS;
            cur_par    <= PAR_NONE;
            cur_stop2  <= 1'b0;
            cur_div_m1 <= '0;
            tx         <= IDLE_LEVEL;
            hold_empty <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            par_acc    <= par_acc_n;
            cur_bits   <= cur_bits_n;
            cur_par    <= cur_par_n;
            cur_stop2  <= cur_stop2_n;
            cur_div_m1 <= cur_div_m1_n;
            tx         <= tx_n;
            if (load)
                hold_empty <= 1'b0;
            else if (take)
                hold_empty <= 1'b1;
        end
    end

    // Payload registers: the held word with its format, and the shifter.
    always_ff @(posedge clk) begin
        // NOTE: these carry no reset; they are only read after being loaded,
        // and the validity flag (hold_empty) and sequencer state are reset.
        if (load) begin
            hold_data   <= s_data;
            hold_bits   <= cfg_bits_c;
            hold_par    <= cfg_par_c;
            hold_stop2  <= cfg_stop2;
            hold_div_m1 <= cfg_div_m1_c;
        end
        shreg <= shreg_n;
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param.
// Senders push the expected frame into a scoreboard queue when a word is
// accepted; the monitor pops it when the line goes busy and compares the
// line level, tx_done and tx_busy clock by clock.
module tb_uart_tx_param;

    localparam int DATA_W = 9;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [3:0]        cfg_data_bits = 4'd8;
    logic [2:0]        cfg_parity = 3'd0;
    logic              cfg_stop2 = 1'b0;
    logic [DIV_W-1:0]  cfg_baud_div = 16'd1;
    logic              tx;
    logic              tx_busy;
    logic              tx_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        logic [8:0]  data;
        logic [3:0]  bits;
        logic [2:0]  par;
        logic        stop2;
        logic [15:0] div;
        logic [15:0] pat;    // expected line level per bit, bit 0 = start
        int          nbits;
        int          ediv;   // effective clocks per bit
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] pat;
        int          nbits;
        int          ediv;
        int          acc;    // cycle stamp of the accepting negedge
        bit          chain;  // must follow the previous frame with no gap
    } exp_t;

    exp_t exp_q[$];
    int   acc_log[$];
    int   start_log[$];
    vec_t vecs[6];

    uart_tx_param #(.DATA_W(DATA_W), .DIV_W(DIV_W), .IDLE_LEVEL(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .cfg_baud_div  (cfg_baud_div),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done)
    );

    always #5 clk = ~clk;

    // Free-running cycle stamp; read only at negedges.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Offer one word, wait for acceptance, log the expected frame, then
    // disturb the config inputs to prove the frame uses the captured copy.
    task automatic send(input vec_t v, input bit chain);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        s_data        = v.data;
        cfg_data_bits = v.bits;
        cfg_parity    = v.par;
        cfg_stop2     = v.stop2;
        cfg_baud_div  = v.div;
        s_valid       = 1'b1;
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({v.name, "_accept"}, s_ready, 1'b1);
        if (!s_ready) begin
            s_valid = 1'b0;
            return;
        end
        e = '{v.name, v.pat, v.nbits, v.ediv, cyc, chain};
        exp_q.push_back(e);
        acc_log.push_back(cyc);
        @(negedge clk);
        s_valid       = 1'b0;
        s_data        = ~v.data;
        cfg_data_bits = ~v.bits;
        cfg_parity    = v.par ^ 3'd3;
        cfg_stop2     = ~v.stop2;
        cfg_baud_div  = v.div + 16'd5;
        check({v.name, "_ready_drop"}, s_ready, 1'b0);
    endtask

    // Watch nframes frames on the line and compare against the scoreboard.
    task automatic monitor(input int nframes);
        int prev_end = 0;
        for (int f = 0; f < nframes; f++) begin
            exp_t e;
            int   n = 0;
            int   start;
            int   wave_err = 0;
            int   done_err = 0;
            int   busy_err = 0;
            @(negedge clk);
            while (!tx_busy && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check("frame_seen", tx_busy, 1'b1);
            if (!tx_busy) return;
            check("frame_record", exp_q.size() != 0, 1'b1);
            if (exp_q.size() == 0) return;
            e = exp_q.pop_front();
            start = cyc;
            start_log.push_back(start);
            if (e.chain)
                check({e.name, "_gap"}, start - prev_end, 1);
            else
                check({e.name, "_latency"}, start - e.acc, 2);
            for (int b = 0; b < e.nbits; b++) begin
                for (int c = 0; c < e.ediv; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (tx !== e.pat[b]) wave_err++;
                    if (tx_done !== ((b == e.nbits - 1) && (c == e.ediv - 1))) done_err++;
                    if (tx_busy !== 1'b1) busy_err++;
                end
            end
            prev_end = cyc;
            check({e.name, "_wave_errs"}, wave_err, 0);
            check({e.name, "_done_errs"}, done_err, 0);
            check({e.name, "_busy_errs"}, busy_err, 0);
        end
        @(negedge clk);
        check("idle_busy", tx_busy, 1'b0);
        check("idle_tx", tx, 1'b1);
        check("idle_done", tx_done, 1'b0);
        check("idle_ready", s_ready, 1'b1);
    endtask

    initial begin
        vec_t w1, w2, w3, rv;
        int   n;

        //            name                 data    bits  par   st2   div     pat       nb  ediv
        vecs[0] = '{"8n1_55",            9'h055, 4'd8, 3'd0, 1'b0, 16'd4, 16'h02AA, 10, 4};
        vecs[1] = '{"7e2_41",            9'h041, 4'd7, 3'd1, 1'b1, 16'd3, 16'h0682, 11, 3};
        vecs[2] = '{"7o2_41",            9'h041, 4'd7, 3'd2, 1'b1, 16'd3, 16'h0782, 11, 3};
        vecs[3] = '{"div0_bits3_space",  9'h1FB, 4'd3, 3'd4, 1'b0, 16'd0, 16'h00B6, 8,  1};
        vecs[4] = '{"bits12_par6_none",  9'h12D, 4'd12, 3'd6, 1'b0, 16'd1, 16'h065A, 11, 1};
        vecs[5] = '{"6m1_00",            9'h000, 4'd6, 3'd3, 1'b0, 16'd2, 16'h0180, 9,  2};
        w1 = '{"b2b_1ff", 9'h1FF, 4'd9, 3'd3, 1'b0, 16'd2, 16'h0FFE, 12, 2};
        w2 = '{"b2b_000", 9'h000, 4'd9, 3'd3, 1'b0, 16'd2, 16'h0C00, 12, 2};
        w3 = '{"b2b_0a5", 9'h0A5, 4'd9, 3'd3, 1'b0, 16'd2, 16'h0D4A, 12, 2};
        rv = '{"rst_mid", 9'h000, 4'd8, 3'd0, 1'b0, 16'd8, 16'h0200, 10, 8};

        // Reset state, during and after reset.
        #12;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_ready", s_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_tx", tx, 1'b1);
        check("post_rst_busy", tx_busy, 1'b0);
        check("post_rst_ready", s_ready, 1'b1);

        // Table-driven single frames.
        for (int i = 0; i < 6; i++) begin
            fork
                send(vecs[i], 1'b0);
                monitor(1);
            join
        end

        // Back-to-back frames, the third offered while the holding register
        // is still full so it lands the clock after the second is taken.
        acc_log.delete();
        start_log.delete();
        fork
            begin
                send(w1, 1'b0);
                send(w2, 1'b1);
                send(w3, 1'b1);
            end
            monitor(3);
        join
        check("b2b_frames_logged", start_log.size(), 3);
        if (start_log.size() == 3 && acc_log.size() == 3)
            check("b2b_late_accept", acc_log[2], start_log[1]);

        // Reset in the middle of data bit 3 with a second word held.
        fork
            begin
                send(rv, 1'b0);
                send(rv, 1'b1);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!tx_busy && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                check("rst_mid_busy", tx_busy, 1'b1);
                repeat (35) @(negedge clk);
            end
        join
        check("rst_mid_pre_tx", tx, 1'b0);
        check("rst_mid_pre_ready", s_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy_low", tx_busy, 1'b0);
        check("rst_mid_done", tx_done, 1'b0);
        check("rst_mid_ready", s_ready, 1'b1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid_after_tx", tx, 1'b1);
        check("rst_mid_after_busy", tx_busy, 1'b0);

        // Clean frame after the aborted one.
        fork
            send(vecs[0], 1'b0);
            monitor(1);
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
